// File: rtl/msrh_lsu_pkg.sv
// rtl/msrh_lsu_pkg.sv - LSU shared types and constants for the snoop aggregator
//
// Contents:
//   snoop_agg_state_t  engine states (IDLE/ISSUE/WAIT/RESP)
//   snoop_src_state_t  per-responder states (S_IDLE/S_WAIT/S_DONE)
//   SNOOP_SRC_*        responder index / merge priority (higher index wins)
package msrh_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } snoop_agg_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } snoop_src_state_t;

  localparam int SNOOP_SRC_L1D = 0;
  localparam int SNOOP_SRC_STQ = 1;

endpackage

// File: rtl/msrh_snoop_req_fifo.sv
// rtl/msrh_snoop_req_fifo.sv - snoop request FIFO with registered occupancy count
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   push, push_data   write request (ignored while full)
//   pop               read request (ignored while empty)
//   head              oldest entry
//   full, empty       derived from the registered count only
module msrh_snoop_req_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/msrh_snoop_agg.sv
// rtl/msrh_snoop_agg.sv - snoop aggregator: queue, broadcast, replay, priority merge
//
// Ports:
//   i_clk, i_reset_n                       clock, asynchronous active-low reset
//   i_req_valid/o_req_ready/i_req_paddr    incoming snoop (push into request FIFO)
//   o_resp_valid/i_resp_ready              merged response handshake
//   o_resp_data/o_resp_be/o_resp_error     merged payload, error = replay budget exhausted
//   o_src_req_valid/o_src_req_paddr        per-source request pulses, shared aligned address
//   i_src_resp_valid/_conflict/_data/_be   per-source responses, packed by source index
module msrh_snoop_agg
  import msrh_lsu_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int DATA_W      = 128,
  parameter int PADDR_W     = 56,
  parameter int REQ_Q_DEPTH = 2,
  parameter int MAX_REPLAY  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [PADDR_W-1:0]            i_req_paddr,
  output logic                          o_resp_valid,
  input  logic                          i_resp_ready,
  output logic [DATA_W-1:0]             o_resp_data,
  output logic [DATA_W/8-1:0]           o_resp_be,
  output logic                          o_resp_error,
  output logic [NUM_SRC-1:0]            o_src_req_valid,
  output logic [PADDR_W-1:0]            o_src_req_paddr,
  input  logic [NUM_SRC-1:0]            i_src_resp_valid,
  input  logic [NUM_SRC-1:0]            i_src_resp_conflict,
  input  logic [NUM_SRC*DATA_W-1:0]     i_src_resp_data,
  input  logic [NUM_SRC*(DATA_W/8)-1:0] i_src_resp_be
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_REPLAY + 1);

  snoop_agg_state_t  state_q, state_d;
  snoop_src_state_t  src_state_q [NUM_SRC];
  snoop_src_state_t  src_state_d [NUM_SRC];
  logic [CNT_W-1:0]  cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  cnt_d [NUM_SRC];
  logic [DATA_W-1:0] data_q [NUM_SRC];
  logic [BE_W-1:0]   be_q [NUM_SRC];
  logic [NUM_SRC-1:0] replay_q, replay_d;
  logic [NUM_SRC-1:0] store, exhaust;
  logic [PADDR_W-1:0] paddr_q;
  logic               err_q;
  logic               all_done;
  logic               pop;
  logic               fifo_full, fifo_empty;
  logic [PADDR_W-1:0] fifo_head;
  logic [DATA_W-1:0]  merged_data;
  logic [BE_W-1:0]    merged_be;
  logic               resp_active;

  msrh_snoop_req_fifo #(
    .WIDTH (PADDR_W),
    .DEPTH (REQ_Q_DEPTH)
  ) u_req_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (i_req_valid),
    .push_data (i_req_paddr),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready comes from the registered count: a same-cycle pop does not free a slot early.
  assign o_req_ready = !fifo_full;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    all_done = 1'b1;
    replay_d = '0;
    store    = '0;
    exhaust  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_state_d[s] = src_state_q[s];
      cnt_d[s]       = cnt_q[s];
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
          for (int s = 0; s < NUM_SRC; s++) cnt_d[s] = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        for (int s = 0; s < NUM_SRC; s++) src_state_d[s] = S_WAIT;
      end
      WAIT: begin
        // Each source advances independently; a replay and another source's
        // completion in the same cycle do not interact.
        for (int s = 0; s < NUM_SRC; s++) begin
          if (src_state_q[s] == S_WAIT && i_src_resp_valid[s]) begin
            if (i_src_resp_conflict[s]) begin
              if (cnt_q[s] < CNT_W'(MAX_REPLAY)) begin
                cnt_d[s]    = cnt_q[s] + 1'b1;
                replay_d[s] = 1'b1;
              end else begin
                src_state_d[s] = S_DONE;
                exhaust[s]     = 1'b1;
              end
            end else begin
              src_state_d[s] = S_DONE;
              store[s]       = 1'b1;
            end
          end
          if (src_state_d[s] != S_DONE) all_done = 1'b0;
        end
        // Looking at next-state lets the response appear the cycle after the last source finishes.
        if (all_done) state_d = RESP;
      end
      RESP: begin
        if (i_resp_ready) begin
          state_d = IDLE;
          for (int s = 0; s < NUM_SRC; s++) src_state_d[s] = S_IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      replay_q <= '0;
      err_q    <= 1'b0;
      paddr_q  <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        src_state_q[s] <= S_IDLE;
        cnt_q[s]       <= '0;
        data_q[s]      <= '0;
        be_q[s]        <= '0;
      end
    end else begin
      state_q  <= state_d;
      replay_q <= replay_d;
      if (pop) begin
        paddr_q <= fifo_head & ~(PADDR_W'(BE_W - 1));
        err_q   <= 1'b0;
      end else if (|exhaust) begin
        err_q <= 1'b1;
      end else if (state_q == RESP && i_resp_ready) begin
        err_q <= 1'b0;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        src_state_q[s] <= src_state_d[s];
        cnt_q[s]       <= cnt_d[s];
        // Exhausted sources keep the be=0 cleared here.
        if (pop) begin
          data_q[s] <= '0;
          be_q[s]   <= '0;
        end else if (store[s]) begin
          data_q[s] <= i_src_resp_data[s*DATA_W +: DATA_W];
          be_q[s]   <= i_src_resp_be[s*BE_W +: BE_W];
        end
      end
    end
  end

  // Ascending scan so the highest-indexed enabled source owns each byte.
  always_comb begin
    merged_data = '0;
    merged_be   = '0;
    for (int b = 0; b < BE_W; b++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (be_q[s][b]) begin
          merged_data[b*8 +: 8] = data_q[s][b*8 +: 8];
          merged_be[b]          = 1'b1;
        end
      end
    end
  end

  assign resp_active     = (state_q == RESP);
  assign o_resp_valid    = resp_active;
  assign o_resp_data     = resp_active ? merged_data : '0;
  assign o_resp_be       = resp_active ? merged_be : '0;
  assign o_resp_error    = resp_active & err_q;
  assign o_src_req_valid = (state_q == ISSUE) ? {NUM_SRC{1'b1}} : replay_q;
  assign o_src_req_paddr = paddr_q;

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (i_src_resp_valid[s] && src_state_q[s] != S_WAIT)
          $error("msrh_snoop_agg: response from source %0d while not waiting", s);
      end
    end
  end
`endif

endmodule

// File: tb/tb_msrh_snoop_agg.sv
// tb/tb_msrh_snoop_agg.sv - directed self-checking bench for msrh_snoop_agg
module tb_msrh_snoop_agg;
  import msrh_lsu_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 128;
  localparam int PADDR_W = 56;
  localparam int BE_W    = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [PADDR_W-1:0]    req_paddr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_data;
  logic [BE_W-1:0]       resp_be;
  logic                  resp_error;
  logic [NUM_SRC-1:0]    src_req_valid;
  logic [PADDR_W-1:0]    src_req_paddr;
  logic [NUM_SRC-1:0]    src_resp_valid;
  logic [NUM_SRC-1:0]    src_resp_conflict;
  logic [NUM_SRC*DATA_W-1:0] src_resp_data;
  logic [NUM_SRC*BE_W-1:0]   src_resp_be;

  int checks   = 0;
  int failures = 0;
  int pulse0   = 0;
  int pulse1   = 0;

  always #5 clk = ~clk;

  msrh_snoop_agg #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .PADDR_W(PADDR_W),
    .REQ_Q_DEPTH(2), .MAX_REPLAY(2)
  ) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_paddr         (req_paddr),
    .o_resp_valid        (resp_valid),
    .i_resp_ready        (resp_ready),
    .o_resp_data         (resp_data),
    .o_resp_be           (resp_be),
    .o_resp_error        (resp_error),
    .o_src_req_valid     (src_req_valid),
    .o_src_req_paddr     (src_req_paddr),
    .i_src_resp_valid    (src_resp_valid),
    .i_src_resp_conflict (src_resp_conflict),
    .i_src_resp_data     (src_resp_data),
    .i_src_resp_be       (src_resp_be)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      pulse0 = pulse0 + int'(src_req_valid[SNOOP_SRC_L1D]);
      pulse1 = pulse1 + int'(src_req_valid[SNOOP_SRC_STQ]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PADDR_W-1:0] a);
    req_valid = 1'b1;
    req_paddr = a;
    tick();
    req_valid = 1'b0;
    req_paddr = '0;
  endtask

  task automatic respond(input logic [1:0] v, input logic [1:0] c,
                         input logic [DATA_W-1:0] d0, input logic [BE_W-1:0] b0,
                         input logic [DATA_W-1:0] d1, input logic [BE_W-1:0] b1);
    src_resp_valid    = v;
    src_resp_conflict = c;
    src_resp_data     = {d1, d0};
    src_resp_be       = {b1, b0};
    tick();
    src_resp_valid    = '0;
    src_resp_conflict = '0;
    src_resp_data     = '0;
    src_resp_be       = '0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL reset_resp_error got=%0b exp=0", resp_error); end
    checks++; if (src_req_valid !== 2'b00) begin failures++; $display("FAIL reset_src_req_valid got=%b exp=00", src_req_valid); end
    checks++; if (resp_data !== '0 || resp_be !== '0) begin failures++; $display("FAIL reset_payload got=%h/%h exp=0/0", resp_data, resp_be); end
    checks++; if (src_req_paddr !== '0) begin failures++; $display("FAIL reset_src_paddr got=%h exp=0", src_req_paddr); end
  endtask

  task automatic test_single();
    push(56'h8000_1234);
    checks++; if (src_req_valid !== 2'b00) begin failures++; $display("FAIL single_c1_src_valid got=%b exp=00", src_req_valid); end
    tick();
    checks++; if (src_req_valid !== 2'b11) begin failures++; $display("FAIL single_c2_src_valid got=%b exp=11", src_req_valid); end
    checks++; if (src_req_paddr !== 56'h8000_1230) begin failures++; $display("FAIL single_paddr got=%h exp=80001230", src_req_paddr); end
    tick();
    checks++; if (src_req_valid !== 2'b00) begin failures++; $display("FAIL single_c3_src_valid got=%b exp=00", src_req_valid); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_c3_resp_valid got=%0b exp=0", resp_valid); end
    respond(2'b11, 2'b00, {16{8'hAA}}, 16'hFFFF, {16{8'h55}}, 16'h0000);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_c4_resp_valid got=%0b exp=1", resp_valid); end
    checks++; if (resp_data !== {16{8'hAA}}) begin failures++; $display("FAIL single_data got=%h exp=%h", resp_data, {16{8'hAA}}); end
    checks++; if (resp_be !== 16'hFFFF) begin failures++; $display("FAIL single_be got=%h exp=ffff", resp_be); end
    checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL single_error got=%0b exp=0", resp_error); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_after_hs_valid got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_overlap_merge();
    logic [DATA_W-1:0] exp_d;
    exp_d = {{12{8'h11}}, {4{8'h22}}};
    push(56'h0000_2000);
    tick();
    tick();
    respond(2'b11, 2'b00, {16{8'h11}}, 16'hFFFF, {16{8'h22}}, 16'h000F);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL merge_valid got=%0b exp=1", resp_valid); end
    checks++; if (resp_data !== exp_d) begin failures++; $display("FAIL merge_data got=%h exp=%h", resp_data, exp_d); end
    checks++; if (resp_be !== 16'hFFFF) begin failures++; $display("FAIL merge_be got=%h exp=ffff", resp_be); end
    tick();
  endtask

  task automatic test_conflict_replay();
    int b0, b1;
    b0 = pulse0;
    b1 = pulse1;
    push(56'h0000_3010);
    tick();
    tick();
    respond(2'b11, 2'b01, '0, 16'h0000, {16{8'h99}}, 16'h0000);
    checks++; if (src_req_valid !== 2'b01) begin failures++; $display("FAIL replay_pulse1 got=%b exp=01", src_req_valid); end
    tick();
    respond(2'b01, 2'b01, '0, 16'h0000, '0, 16'h0000);
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL replay_early_valid got=%0b exp=0", resp_valid); end
    respond(2'b01, 2'b00, {16{8'h33}}, 16'hFFFF, '0, 16'h0000);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL replay_valid got=%0b exp=1", resp_valid); end
    checks++; if (resp_data !== {16{8'h33}}) begin failures++; $display("FAIL replay_data got=%h exp=%h", resp_data, {16{8'h33}}); end
    checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL replay_error got=%0b exp=0", resp_error); end
    checks++; if (pulse0 - b0 != 3) begin failures++; $display("FAIL replay_src0_pulses got=%0d exp=3", pulse0 - b0); end
    checks++; if (pulse1 - b1 != 1) begin failures++; $display("FAIL replay_src1_pulses got=%0d exp=1", pulse1 - b1); end
    tick();
  endtask

  task automatic test_replay_exhaust();
    int b0;
    logic [DATA_W-1:0] exp_d;
    exp_d = '0;
    exp_d[63:32] = 32'h4444_4444;
    b0 = pulse0;
    push(56'h0000_4000);
    tick();
    tick();
    respond(2'b11, 2'b01, {16{8'hEE}}, 16'hFFFF, {16{8'h44}}, 16'h00F0);
    tick();
    respond(2'b01, 2'b01, {16{8'hEE}}, 16'hFFFF, '0, 16'h0000);
    tick();
    respond(2'b01, 2'b01, {16{8'hEE}}, 16'hFFFF, '0, 16'h0000);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL exhaust_valid got=%0b exp=1", resp_valid); end
    checks++; if (resp_error !== 1'b1) begin failures++; $display("FAIL exhaust_error got=%0b exp=1", resp_error); end
    checks++; if (resp_be !== 16'h00F0) begin failures++; $display("FAIL exhaust_be got=%h exp=00f0", resp_be); end
    checks++; if (resp_data !== exp_d) begin failures++; $display("FAIL exhaust_data got=%h exp=%h", resp_data, exp_d); end
    checks++; if (pulse0 - b0 != 3) begin failures++; $display("FAIL exhaust_src0_pulses got=%0d exp=3", pulse0 - b0); end
    tick();
    checks++; if (resp_error !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL exhaust_after_hs got=%0b/%0b exp=0/0", resp_valid, resp_error); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0]  dq [2];
    logic [PADDR_W-1:0] pq [2];
    dq[0] = {16{8'hB2}};
    dq[1] = {16{8'hC3}};
    pq[0] = 56'h00_0000_1000_0040;
    pq[1] = 56'hFF_FFFF_FFFF_FFF0;
    resp_ready = 1'b0;
    push(56'h80_0000_0008);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_b got=%0b exp=1", req_ready); end
    push(56'h00_0000_1000_004F);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_c got=%0b exp=1", req_ready); end
    push(56'hFF_FFFF_FFFF_FFFF);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", req_ready); end
    respond(2'b11, 2'b00, {16{8'hA1}}, 16'hFFFF, '0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== {16{8'hA1}} || resp_be !== 16'hFFFF) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%0b/%h/%h exp=1/%h/ffff", i, resp_valid, resp_data, resp_be, {16{8'hA1}});
      end
      tick();
    end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%0b exp=0", req_ready); end
    resp_ready = 1'b1;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_at_ready got=%0b exp=1", resp_valid); end
    tick();
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 10 && src_req_valid !== 2'b11; w++) tick();
      checks++; if (src_req_valid !== 2'b11) begin failures++; $display("FAIL bp_issue%0d got=%b exp=11", k, src_req_valid); end
      checks++; if (src_req_paddr !== pq[k]) begin failures++; $display("FAIL bp_paddr%0d got=%h exp=%h", k, src_req_paddr, pq[k]); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop%0d got=%0b exp=1", k, req_ready); end
      tick();
      respond(2'b11, 2'b00, dq[k], 16'hFFFF, '0, 16'h0000);
      checks++; if (resp_valid !== 1'b1 || resp_data !== dq[k]) begin failures++; $display("FAIL bp_order%0d got=%0b/%h exp=1/%h", k, resp_valid, resp_data, dq[k]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen_valid, seen_req;
    seen_valid = 1'b0;
    seen_req   = 1'b0;
    resp_ready = 1'b1;
    push(56'h0000_5000);
    push(56'h0000_6000);
    tick();
    checks++; if (src_req_paddr !== 56'h0000_5000) begin failures++; $display("FAIL rst_pre_paddr got=%h exp=5000", src_req_paddr); end
    rst_n = 1'b0;
    #1;
    checks++; if (src_req_paddr !== '0) begin failures++; $display("FAIL rst_paddr got=%h exp=0", src_req_paddr); end
    checks++; if (resp_valid !== 1'b0 || src_req_valid !== 2'b00 || req_ready !== 1'b1 || resp_error !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got=%0b/%b/%0b/%0b exp=0/00/1/0", resp_valid, src_req_valid, req_ready, resp_error);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (resp_valid) seen_valid = 1'b1;
      if (|src_req_valid) seen_req = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL rst_no_resp got=%0b exp=0", seen_valid); end
    checks++; if (seen_req !== 1'b0) begin failures++; $display("FAIL rst_no_issue got=%0b exp=0", seen_req); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_fifo_empty got=%0b exp=1", req_ready); end
  endtask

  initial begin
    rst_n             = 1'b0;
    req_valid         = 1'b0;
    req_paddr         = '0;
    resp_ready        = 1'b1;
    src_resp_valid    = '0;
    src_resp_conflict = '0;
    src_resp_data     = '0;
    src_resp_be       = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_overlap_merge();
    test_conflict_replay();
    test_replay_exhaust();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
